// File: rtl/avr_spi_tx_pkg.sv
// Shared definitions for the AVR link return path: idle frame, status layout and
// transmitter state encoding.
package rk_avr_pkg;

  localparam logic [15:0] IDLE_FRAME_DFLT = 16'h0000;
  localparam int          FRAME_BITS      = 16;

  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_EMPTY = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } tx_state_e;

  // Bits 4:3 read as zero; the count field is the low three bits.
  function automatic logic [7:0] pack_status(input logic ovf, input logic full,
                                             input logic empty, input logic [2:0] cnt);
    logic [7:0] s;
    s           = 8'h00;
    s[ST_OVF]   = ovf;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[2:0]      = cnt;
    return s;
  endfunction

endpackage

// File: rtl/avr_spi_tx_if.sv
// CPU register port and AVR SPI pins of the keyboard return-path transmitter.
interface avr_spi_tx_if;
  import rk_avr_pkg::*;

  logic       addr;
  logic       we_n;
  logic       rd_n;
  logic [7:0] idata;
  logic [7:0] odata;
  logic       spi_sck;
  logic       spi_ncs;
  logic       spi_miso;
  logic       fifo_empty;

  modport slave (
    input  addr, we_n, rd_n, idata, spi_sck, spi_ncs,
    output odata, spi_miso, fifo_empty
  );

  modport master (
    output addr, we_n, rd_n, idata, spi_sck, spi_ncs,
    input  odata, spi_miso, fifo_empty
  );

endinterface

// File: rtl/avr_spi_tx_fifo.sv
// Synchronous FIFO of tag/data words; a push and a pop in the same cycle both
// take effect, even when full.
module avr_tx_fifo
  import rk_avr_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int DATA_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/avr_spi_tx.sv
// SPI slave transmitter: queues CPU tag/data pairs and shifts one 16-bit frame
// per AVR chip-select window on MISO (mode 0, MSB first).
module avr_spi_tx
  import rk_avr_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 2,
  parameter logic [15:0] IDLE_FRAME  = IDLE_FRAME_DFLT,
  parameter int          SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset,
  avr_spi_tx_if.slave  bus
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // SPI pin synchronizers run through reset so a held-low NCS is not seen as a new fall
  logic [SYNC_N-1:0] sck_sync_q, ncs_sync_q;
  logic              sck_prev_q, ncs_prev_q;
  logic              sck_rise, sck_fall, ncs_rise, ncs_fall;

  always_ff @(posedge clk) begin
    sck_sync_q <= {sck_sync_q[SYNC_N-2:0], bus.spi_sck};
    ncs_sync_q <= {ncs_sync_q[SYNC_N-2:0], bus.spi_ncs};
    sck_prev_q <= sck_sync_q[SYNC_N-1];
    ncs_prev_q <= ncs_sync_q[SYNC_N-1];
  end

  assign sck_rise =  sck_sync_q[SYNC_N-1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[SYNC_N-1] &  sck_prev_q;
  assign ncs_rise =  ncs_sync_q[SYNC_N-1] & ~ncs_prev_q;
  assign ncs_fall = ~ncs_sync_q[SYNC_N-1] &  ncs_prev_q;

  logic              we_n_q, rd_n_q;
  logic [7:0]        tag_q, tag_d;
  logic              ovf_q, ovf_d;
  logic              we_fall, rd_rise, push;
  logic              pop;
  logic [15:0]       fifo_head;
  logic              fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;

  assign we_fall = we_n_q & ~bus.we_n;
  assign rd_rise = ~rd_n_q & bus.rd_n;
  assign push    = we_fall & bus.addr;

  avr_tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (16)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i ({tag_q, bus.idata}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // An overflow flagged in the same cycle as a status-read clear stays set
  always_comb begin
    tag_d = tag_q;
    ovf_d = ovf_q;
    if (we_fall && !bus.addr)            tag_d = bus.idata;
    if (rd_rise && !bus.addr)            ovf_d = 1'b0;
    if (push && fifo_full && !pop)       ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      tag_q  <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      we_n_q <= bus.we_n;
      rd_n_q <= bus.rd_n;
      tag_q  <= tag_d;
      ovf_q  <= ovf_d;
    end
  end

  // After reset only the empty flag is set, so status reads 8'h20
  assign bus.odata      = pack_status(ovf_q, fifo_full, fifo_empty, 3'(fifo_count));
  assign bus.fifo_empty = fifo_empty;

  tx_state_e   state_q, state_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic        from_fifo_q, from_fifo_d;
  logic        miso_q, miso_d;

  // Frame contents are snapshotted at NCS fall; NCS rise outranks any SCK edge
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    from_fifo_d = from_fifo_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ncs_fall) begin
          shreg_d     = fifo_empty ? IDLE_FRAME : fifo_head;
          from_fifo_d = ~fifo_empty;
          bitcnt_d    = '0;
          state_d     = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (ncs_rise) begin
          state_d = S_IDLE;
        end else begin
          if (sck_rise) begin
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == 5'(FRAME_BITS - 1)) state_d = S_DONE;
          end
          if (sck_fall) shreg_d = {shreg_q[14:0], 1'b0};
        end
      end
      S_DONE: begin
        if (ncs_rise) begin
          pop     = from_fifo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    miso_d = (state_d == S_ACTIVE) & shreg_d[15];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      from_fifo_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      from_fifo_q <= from_fifo_d;
      miso_q      <= miso_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign bus.spi_miso = miso_q;

endmodule

// File: tb/tb_avr_spi_tx.sv
// Randomized bench for avr_spi_tx: a CPU/AVR driver plus a queue-based model of
// the tag/data FIFO, overflow flag and frame contents.
module tb_avr_spi_tx;
  import rk_avr_pkg::*;

  localparam int DEPTH_LOG2  = 2;
  localparam int DEPTH       = 1 << DEPTH_LOG2;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avr_spi_tx_if bus();

  avr_spi_tx #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .IDLE_FRAME  (16'h0000),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mq[$];
  logic        m_ovf;
  logic [7:0]  m_tag;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    int n;
    n = mq.size();
    return {m_ovf, n == DEPTH, n == 0, 2'b00, 3'(n)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_tag = 8'h00;
  endtask

  task automatic model_push(input logic [7:0] d);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back({m_tag, d});
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.idata = d; bus.we_n = 1'b0;
    @(negedge clk);
    bus.we_n = 1'b1;
    if (!a) m_tag = d;
    else    model_push(d);
  endtask

  task automatic push_pair(input logic [15:0] w);
    cpu_write(1'b0, w[15:8]);
    cpu_write(1'b1, w[7:0]);
  endtask

  task automatic status_read(input string tag);
    @(negedge clk);
    bus.addr = 1'b0; bus.rd_n = 1'b0;
    @(negedge clk);
    chk(tag, {24'h0, bus.odata}, {24'h0, exp_status()});
    bus.rd_n = 1'b1;
    m_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic spi_open(input int half);
    @(negedge clk);
    bus.spi_ncs = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic spi_bits(input int n, input int half, inout logic [15:0] got);
    for (int i = 0; i < n; i++) begin
      got = {got[14:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      repeat (half) @(negedge clk);
      bus.spi_sck = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic spi_close();
    bus.spi_ncs = 1'b1;
    repeat (SYNC_STAGES + 3) @(negedge clk);
  endtask

  task automatic full_frame(input string tag, input int half);
    logic [15:0] got, exp;
    got = '0;
    exp = (mq.size() != 0) ? mq[0] : 16'h0000;
    spi_open(half);
    spi_bits(16, half, got);
    spi_close();
    if (mq.size() != 0) void'(mq.pop_front());
    chk(tag, {16'h0, got}, {16'h0, exp});
    chk({tag, "_empty"}, {31'h0, bus.fifo_empty}, {31'h0, mq.size() == 0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got, w, exp;
    bus.addr = 1'b0; bus.we_n = 1'b1; bus.rd_n = 1'b1; bus.idata = 8'h00;
    bus.spi_sck = 1'b0; bus.spi_ncs = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_miso", {31'h0, bus.spi_miso}, 32'h0);
    chk("rst_empty", {31'h0, bus.fifo_empty}, 32'h1);
    status_read("rst_status");
    full_frame("idle_frame", 5);
    status_read("idle_status");

    push_pair(16'hA53C);
    full_frame("a53c_frame", 5);
    status_read("a53c_status");

    for (int i = 0; i < DEPTH; i++) push_pair(16'($urandom));
    push_pair(16'($urandom));
    status_read("ovf_status");
    status_read("ovf_cleared");
    for (int i = 0; i < DEPTH; i++) full_frame("ovf_drain", 5);

    push_pair(16'h1234);
    got = '0;
    spi_open(5);
    spi_bits(7, 5, got);
    spi_close();
    status_read("abort_status");
    full_frame("abort_resend", 5);

    // Fill, then land a push on the exact cycle of the NCS-rise pop
    for (int i = 0; i < DEPTH; i++) push_pair(16'($urandom));
    cpu_write(1'b0, 8'($urandom));
    w = {m_tag, 8'($urandom)};
    exp = mq[0];
    got = '0;
    spi_open(5);
    spi_bits(16, 5, got);
    bus.spi_ncs = 1'b1;
    repeat (SYNC_STAGES) @(negedge clk);
    bus.addr = 1'b1; bus.idata = w[7:0]; bus.we_n = 1'b0;
    @(negedge clk);
    bus.we_n = 1'b1;
    repeat (3) @(negedge clk);
    void'(mq.pop_front());
    mq.push_back(w);
    chk("pushpop_frame", {16'h0, got}, {16'h0, exp});
    status_read("pushpop_status");
    for (int i = 0; i < DEPTH; i++) full_frame("pushpop_drain", 5);

    push_pair(16'hBEEF);
    got = '0;
    spi_open(5);
    spi_bits(9, 5, got);
    chk("rst_head", {23'h0, got[8:0]}, {23'h0, 9'(16'hBEEF >> 7)});
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    chk("midrst_miso", {31'h0, bus.spi_miso}, 32'h0);
    chk("midrst_status", {24'h0, bus.odata}, {24'h0, exp_status()});
    got = '0;
    spi_bits(7, 5, got);
    chk("midrst_tail", {25'h0, got[6:0]}, 32'h0);
    spi_close();
    status_read("midrst_after");
    full_frame("post_rst_frame", 5);

    for (int it = 0; it < 60; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 4)      cpu_write(1'($urandom), 8'($urandom));
      else if (op <= 6) status_read("rnd_status");
      else              full_frame("rnd_frame", int'($urandom_range(4, 6)));
    end
    while (mq.size() != 0) full_frame("final_drain", 4);
    status_read("final_status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
